// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction sequencer: opcodes, ALU select values,
// FSM state encoding and instruction field positions.
package cpu_pkg;

   localparam logic [2:0] OP_MV      = 3'b000;
   localparam logic [2:0] OP_MVI     = 3'b001;
   localparam logic [2:0] ALU_PASS_A = 3'b000;

   // Instruction layout {op, rx, ry}
   localparam int unsigned OP_MSB = 8;
   localparam int unsigned OP_LSB = 6;
   localparam int unsigned RX_MSB = 5;
   localparam int unsigned RX_LSB = 3;
   localparam int unsigned RY_MSB = 2;
   localparam int unsigned RY_LSB = 0;

   typedef enum logic [1:0] {
      IDLE,
      T1,
      T2,
      T3
   } state_e;

   function automatic logic [2:0] op_of(input logic [8:0] instr);
      return instr[OP_MSB:OP_LSB];
   endfunction

   function automatic logic [2:0] rx_of(input logic [8:0] instr);
      return instr[RX_MSB:RX_LSB];
   endfunction

   function automatic logic [2:0] ry_of(input logic [8:0] instr);
      return instr[RY_MSB:RY_LSB];
   endfunction

endpackage

// File: rtl/control_unit.sv
// Instruction sequencer: accepts {op, rx, ry} on a valid/ready handshake and
// drives the datapath control lines over a fixed T1/T2/T3 execute sequence.
module control_unit
   import cpu_pkg::*;
#(
   parameter int unsigned IW = 9
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          instrValid,
   input  logic [IW-1:0] instrIn,
   output logic          instrReady,
   output logic          done,
   output logic [2:0]    regSel,
   output logic [2:0]    aluSel,
   output logic          Rin,
   output logic          Rout,
   output logic          RAin,
   output logic          RCout,
   output logic          genConst
);

   state_e          state_q, state_d;
   logic [IW-1:0]   ir_q, ir_d;
   logic            accept;
   logic [2:0]      op, rx, ry;

   assign op = op_of(ir_q);
   assign rx = rx_of(ir_q);
   assign ry = ry_of(ir_q);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         ir_q    <= '0;
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
      end
   end

   // Ready only when the next cycle is free to start a new T1.
   assign instrReady = (state_q == IDLE) || (state_q == T3);
   assign accept     = instrValid & instrReady;

   always_comb begin
      state_d = state_q;
      ir_d    = ir_q;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = T1;
               ir_d    = instrIn;
            end
         end
         T1: state_d = T2;
         T2: state_d = T3;
         T3: begin
            if (accept) begin
               state_d = T1;
               ir_d    = instrIn;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      done     = 1'b0;
      regSel   = 3'b000;
      aluSel   = ALU_PASS_A;
      Rin      = 1'b0;
      Rout     = 1'b0;
      RAin     = 1'b0;
      RCout    = 1'b0;
      genConst = 1'b0;
      unique case (state_q)
         IDLE: ;
         T1: begin
            RAin = 1'b1;
            if (op == OP_MV) begin
               regSel = ry;
               Rout   = 1'b1;
            end else if (op == OP_MVI) begin
               regSel   = ry;
               genConst = 1'b1;
            end else begin
               regSel = rx;
               Rout   = 1'b1;
            end
         end
         T2: begin
            // Moves pass A through the ALU with the bus left undriven.
            if (op != OP_MV && op != OP_MVI) begin
               regSel = ry;
               Rout   = 1'b1;
               aluSel = op;
            end
         end
         T3: begin
            regSel = rx;
            RCout  = 1'b1;
            Rin    = 1'b1;
            done   = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed scenarios plus a random
// instruction stream compared cycle by cycle against an instruction-level model.
module tb_control_unit;

   logic       clk = 1'b0;
   logic       rst;
   logic       instrValid;
   logic [8:0] instrIn;
   logic       instrReady, done, Rin, Rout, RAin, RCout, genConst;
   logic [2:0] regSel, aluSel;

   control_unit #(.IW(9)) dut (
      .clk        (clk),
      .rst        (rst),
      .instrValid (instrValid),
      .instrIn    (instrIn),
      .instrReady (instrReady),
      .done       (done),
      .regSel     (regSel),
      .aluSel     (aluSel),
      .Rin        (Rin),
      .Rout       (Rout),
      .RAin       (RAin),
      .RCout      (RCout),
      .genConst   (genConst)
   );

   always #5 clk = ~clk;

   // Record layout: {ready, done, regSel, aluSel, Rin, Rout, RAin, RCout, genConst}
   typedef logic [12:0] rec_t;
   localparam rec_t IDLE_REC = 13'b1_0_000_000_00000;

   rec_t dut_rec;
   assign dut_rec = {instrReady, done, regSel, aluSel, Rin, Rout, RAin, RCout, genConst};

   int   n_checks = 0;
   int   n_errors = 0;
   rec_t exp_q[$];
   int   acc_cnt = 0;
   int   aborted = 0;
   int   done_cnt = 0;
   int   cyc_no = 0;
   int   done_cyc[$];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc_no);
      end
   endtask

   // Expected control record for one execute step of an instruction.
   function automatic rec_t step_rec(input logic [8:0] ins, input int phase);
      logic [2:0] op, rx, ry;
      logic       rdy, dn, rin, rout, rain, rcout, gc;
      logic [2:0] sel, alu;
      op = ins[8:6];
      rx = ins[5:3];
      ry = ins[2:0];
      {rdy, dn, rin, rout, rain, rcout, gc} = '0;
      sel = 3'd0;
      alu = 3'd0;
      if (phase == 1) begin
         rain = 1'b1;
         if (op == 3'd0) begin sel = ry; rout = 1'b1; end
         else if (op == 3'd1) begin sel = ry; gc = 1'b1; end
         else begin sel = rx; rout = 1'b1; end
      end else if (phase == 2) begin
         if (op > 3'd1) begin sel = ry; rout = 1'b1; alu = op; end
      end else begin
         rdy = 1'b1; dn = 1'b1; sel = rx; rcout = 1'b1; rin = 1'b1;
      end
      return {rdy, dn, sel, alu, rin, rout, rain, rcout, gc};
   endfunction

   // One clock cycle: drive inputs, check at the falling edge, advance the model.
   task automatic cyc(input logic v, input logic [8:0] ins);
      rec_t exp;
      logic acc;
      instrValid = v;
      instrIn    = ins;
      @(negedge clk);
      exp = (exp_q.size() != 0) ? exp_q[0] : IDLE_REC;
      check_eq("outs", 32'(dut_rec), 32'(exp));
      check_eq("one_driver", 32'(int'(Rout) + int'(RCout) + int'(genConst) <= 1), 32'd1);
      if (done) begin
         done_cnt++;
         done_cyc.push_back(cyc_no);
      end
      acc = v && exp[12];
      @(posedge clk);
      #1;
      cyc_no++;
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      if (acc) begin
         acc_cnt++;
         for (int p = 1; p <= 3; p++) exp_q.push_back(step_rec(ins, p));
      end
   endtask

   initial begin
      rst        = 1'b1;
      instrValid = 1'b0;
      instrIn    = '0;
      #2;
      check_eq("reset_outs", 32'(dut_rec), 32'(IDLE_REC));
      @(negedge clk);
      #2 rst = 1'b0;
      @(posedge clk);
      #1;

      // ADD r1,r2 then MVI r5,#6
      cyc(1'b1, 9'b010_001_010);
      cyc(1'b0, 9'h000);
      cyc(1'b0, 9'h000);
      cyc(1'b0, 9'h000);
      cyc(1'b1, 9'b001_101_110);
      cyc(1'b0, 9'h1ff);
      cyc(1'b0, 9'h1ff);
      cyc(1'b0, 9'h000);

      // Back-to-back MV r2,r7 then XOR r2,r4 with valid held high
      done_cyc.delete();
      cyc(1'b1, 9'b000_010_111);
      cyc(1'b1, 9'b110_010_100);
      cyc(1'b1, 9'b110_010_100);
      cyc(1'b1, 9'b110_010_100);
      cyc(1'b0, 9'h000);
      cyc(1'b0, 9'h000);
      cyc(1'b0, 9'h000);
      check_eq("b2b_done_count", 32'(done_cyc.size()), 32'd2);
      if (done_cyc.size() == 2)
         check_eq("b2b_done_gap", 32'(done_cyc[1] - done_cyc[0]), 32'd3);

      // Asynchronous reset in T2 of SUB r3,r3
      cyc(1'b1, 9'b011_011_011);
      cyc(1'b0, 9'h000);
      #2 rst = 1'b1;
      #1;
      check_eq("rst_async_outs", 32'(dut_rec), 32'(IDLE_REC));
      if (exp_q.size() != 0) aborted++;
      exp_q.delete();
      @(negedge clk);
      check_eq("rst_held_rin", 32'(Rin), 32'd0);
      check_eq("rst_held_ready", 32'(instrReady), 32'd1);
      #2 rst = 1'b0;
      @(posedge clk);
      #1;
      cyc(1'b1, 9'b010_011_011);
      cyc(1'b0, 9'h000);
      cyc(1'b0, 9'h000);
      cyc(1'b0, 9'h000);

      // Random stream with valid gaps
      begin
         int start_acc;
         int guard;
         start_acc = acc_cnt;
         guard = 0;
         while (acc_cnt - start_acc < 500 && guard < 20000) begin
            cyc($urandom_range(0, 3) != 0, 9'($urandom));
            guard++;
         end
         check_eq("rand_accepts", 32'(acc_cnt - start_acc), 32'd500);
      end
      repeat (4) cyc(1'b0, 9'h000);
      check_eq("done_vs_accept", 32'(done_cnt), 32'(acc_cnt - aborted));

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Instruction sequencer directly upstream of the 8-bit datapath.
- Accepts one 9-bit instruction per valid/ready handshake and drives the datapath control lines (regSel, aluSel, Rin, Rout, RAin, RCout, genConst) over a fixed 3-cycle execute sequence.
- Pulses done when the destination register is written.
- Only driver of datapath control; guarantees at most one bus driver per cycle.

Parameters:
- IW, 9, instruction width; fixed as op[8:6], rx[5:3], ry[2:0]; other values unsupported.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- instrValid  input  1  instrIn holds a valid instruction.
- instrIn  input  9  instruction {op, rx, ry}.
- instrReady  output  1  block accepts instrIn this cycle.
- done  output  1  one-cycle pulse in the cycle the destination register is loaded.
- regSel  output  3  register select, or constant value when genConst=1.
- aluSel  output  3  ALU function select.
- Rin  output  1  selected register loads from the bus.
- Rout  output  1  selected register drives the bus.
- RAin  output  1  ALU A register loads from the bus.
- RCout  output  1  ALU result register drives the bus.
- genConst  output  1  {5'b0, regSel} drives the bus.

Behaviour:
- Reset and register transfer:
  - One clock domain (clk).
  - rst is asynchronous and active-high: state=IDLE, IR=0, all control outputs 0, regSel=0, aluSel=ALU_PASS_A, instrReady=1, done=0.
  - Reset mid-instruction aborts the instruction. No partial register write occurs after reset asserts.
- Opcodes:
  - 000 MV rx,ry: rx <- ry.
  - 001 MVI rx,#ry: rx <- {5'b0, ry}.
  - 010–111 ALU: rx <- rx op ry, with aluSel = op.
- FSM states: IDLE, T1, T2, T3.
- Handshake and sequencing:
  - instrReady=1 in IDLE and T3; 0 in T1 and T2.
  - Accept = instrValid & instrReady. On accept, IR <= instrIn and next state is T1.
  - T1 -> T2 -> T3 unconditionally.
  - From T3: go to T1 if accept, else IDLE. Back-to-back issue gives a 3-cycle throughput.
  - instrIn is ignored when not accepted. IR is stable from T1 through T3.
- Outputs are a combinational decode of state and IR (Moore). Defaults: all enables 0, regSel=0, aluSel=ALU_PASS_A.
  - T1, MV: regSel=ry, Rout=1, RAin=1.
  - T1, MVI: regSel=ry (immediate), genConst=1, RAin=1.
  - T1, ALU: regSel=rx, Rout=1, RAin=1.
  - T2, MV/MVI: aluSel=ALU_PASS_A. The result register captures A at the end of T2; the bus is undriven.
  - T2, ALU: regSel=ry, Rout=1, aluSel=op.
  - T3, all: regSel=rx, RCout=1, Rin=1, done=1.
- Invariants:
  - Rout + RCout + genConst <= 1 in every cycle.
  - Rin only in T3; RAin only in T1.
- Boundary conditions:
  - rx==ry is legal: ADD r3,r3 doubles r3.
  - Immediate range is 0–7.
  - instrValid held high across T1/T2 does not cause a double accept.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode constants OP_MV=3'b000, OP_MVI=3'b001;
  - ALU_PASS_A=3'b000;
  - state enum {IDLE, T1, T2, T3};
  - instruction field positions.
- Single module with no sub-module. The decode is one combinational block, and the state register and IR are one sequential block.

Test Plan:
- Reset, then ADD (instr 9'b010_001_010) at cycle 0 with instrValid=1 -> T1: regSel=1, Rout=1, RAin=1; T2: regSel=2, Rout=1, aluSel=3'b010; T3: regSel=1, RCout=1, Rin=1, done=1; instrReady 1,0,0,1.
- MVI r5,#6 (9'b001_101_110) -> T1: genConst=1, regSel=6, RAin=1; T2: aluSel=000 with no bus driver; T3: regSel=5, Rin=1, RCout=1.
- Back-to-back MV r2,r7 then XOR r2,r4 with instrValid held high -> second accept in T3 of the first; XOR T1 occurs in the next cycle; done pulses exactly 3 cycles apart; no accept during T1/T2.
- Assert rst asynchronously mid-T2 of a SUB -> outputs go to reset values immediately; no Rin pulse; instrReady=1; a new instruction is accepted normally after release.
- Randomized 500-instruction stream with random instrValid gaps -> every cycle Rout+RCout+genConst<=1; done count equals accept count; each output sequence matches the decode table.
